// File: rtl/seg7_pkg.sv
// seg7_pkg: blank pattern, active-low hex glyph table {g,f,e,d,c,b,a} and lookup helper
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    return HEX_GLYPH[h];
  endfunction
endpackage

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: digit scan divider, digit index and registered seg/anode drive.
// Leading-zero blanking of digits above 0 when LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [4*NUM_DIGITS-1:0]   i_count,
  output logic [6:0]                o_seg,
  output logic [NUM_DIGITS-1:0]     o_anode
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [DW-1:0] r_div;
  logic [IW-1:0] r_idx;
  logic [4*NUM_DIGITS-1:0] w_shift;
  logic w_blank;
  assign w_shift = i_count >> {r_idx, 2'b00};
`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank = (r_idx != '0) && (w_shift == '0);
`else
  assign w_blank = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_idx   <= '0;
      o_seg   <= SEG_BLANK;
      o_anode <= '1;
    end else begin
      r_div   <= (r_div == DW'(SCAN_DIV - 1)) ? '0 : r_div + 1'b1;
      if (r_div == DW'(SCAN_DIV - 1))
        r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      o_seg   <= w_blank ? SEG_BLANK : hex_glyph(w_shift[3:0]);
      o_anode <= ~(NUM_DIGITS'(1) << r_idx);
    end
  end
endmodule

// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: prescaled N-digit hex up/down counter with load and wrap pulse,
// scanned onto a common-anode 7-segment display (optional LEADING_ZERO_BLANK_EN).
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                      system_clock,
  input  logic                      system_reset,
  input  logic                      count_en,
  input  logic                      count_dir,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  output logic [4*NUM_DIGITS-1:0]   count,
  output logic                      wrap,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     anode
);
  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] r_pre;
  logic [CW-1:0] r_count;
  logic          r_wrap;
  logic          w_tick;
  assign w_tick = count_en && (r_pre == PW'(PRESCALE - 1));
  assign count  = r_count;
  assign wrap   = r_wrap;
  // load wins over a coincident tick and restarts the prescale period
  always_ff @(posedge system_clock or negedge system_reset) begin
    if (!system_reset) begin
      r_pre   <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_pre   <= '0;
      r_count <= load_value;
      r_wrap  <= 1'b0;
    end else begin
      if (count_en) r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_count <= count_dir ? r_count + 1'b1 : r_count - 1'b1;
      r_wrap <= w_tick && (count_dir ? &r_count : r_count == '0);
    end
  end
  seg7_scan_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .i_clk   (system_clock),
    .i_rst_n (system_reset),
    .i_count (r_count),
    .o_seg   (seg),
    .o_anode (anode)
  );
endmodule

// File: tb/tb_seg7_scan_counter.sv
// tb_seg7_scan_counter: directed, table-driven and random checks against a behavioural model.
module tb_seg7_scan_counter;
  localparam int ND = 4, PS = 4, SD = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h40;
`endif
  localparam logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 0;
  logic rst_n = 1;
  logic en = 1, dir = 1, ld = 0;
  logic [15:0] lv = '0;
  logic [15:0] count;
  logic wrap;
  logic [6:0] seg;
  logic [3:0] anode;
  int n_checks = 0, n_err = 0;
  int m_count, m_pre, m_wrap, m_div, m_idx, m_seg, m_anode;

  always #10 clk = ~clk;

  seg7_scan_counter #(.NUM_DIGITS(ND), .PRESCALE(PS), .SCAN_DIV(SD)) dut (
    .system_clock(clk), .system_reset(rst_n), .count_en(en), .count_dir(dir),
    .load(ld), .load_value(lv), .count(count), .wrap(wrap), .seg(seg), .anode(anode)
  );

  typedef struct packed {
    logic [15:0]      value;
    logic [3:0][6:0]  segs;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_seg(input int c, input int idx);
    int hi;
    hi = c >>> (4 * idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && hi == 0) return 'h7F;
`endif
    return int'(GL[hi % 16]);
  endfunction

  task automatic model_reset();
    m_count = 0; m_pre = 0; m_wrap = 0; m_div = 0; m_idx = 0; m_seg = 'h7F; m_anode = 'hF;
  endtask

  task automatic model_edge();
    int oc, oi;
    bit tick;
    oc = m_count; oi = m_idx;
    tick = en && (m_pre == PS - 1);
    if (ld) begin
      m_count = int'(lv); m_pre = 0; m_wrap = 0;
    end else begin
      if (en) m_pre = tick ? 0 : m_pre + 1;
      m_wrap = 0;
      if (tick && dir) begin m_wrap = (oc == 65535); m_count = (oc + 1) % 65536; end
      if (tick && !dir) begin m_wrap = (oc == 0); m_count = (oc + 65535) % 65536; end
    end
    m_anode = 'hF ^ (1 << oi);
    m_seg = exp_seg(oc, oi);
    if (m_div == SD - 1) begin m_div = 0; m_idx = (m_idx + 1) % ND; end
    else m_div++;
  endtask

  task automatic compare_all();
    chk("count", int'(count), m_count);
    chk("wrap", int'(wrap), m_wrap);
    chk("seg", int'(seg), m_seg);
    chk("anode", int'(anode), m_anode);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_change(input string name, input logic [15:0] old);
    int k;
    k = 0;
    while (count == old && k < 20) begin step(); k++; end
    chk({name, "_timeout"}, int'(count == old), 0);
  endtask

  task automatic do_load(input logic [15:0] v);
    ld = 1; lv = v;
    step();
    ld = 0;
  endtask

  initial begin
    vec_t vecs [5];
    logic [15:0] frozen;
    int d;
    vecs[0] = '{16'h0005, {Z, Z, Z, 7'h12}};
    vecs[1] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[2] = '{16'hABCD, {7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[3] = '{16'hF0E9, {7'h0E, 7'h40, 7'h06, 7'h10}};
    vecs[4] = '{16'h0080, {Z, Z, 7'h00, 7'h40}};

    #2 rst_n = 0;
    model_reset();
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_anode", int'(anode), 'hF);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_wrap", int'(wrap), 0);
    repeat (5) step();
    rst_n = 1;
    repeat (3) step();
    chk("pre_first_tick", int'(count), 0);
    step();
    chk("first_tick", int'(count), 1);
    repeat (96) step();
    chk("count_100", int'(count), 'h19);

    do_load(16'hFFFE);
    chk("load_fffe", int'(count), 'hFFFE);
    wait_change("up1", 16'hFFFE);
    chk("up_ffff", int'(count), 'hFFFF);
    chk("up_ffff_wrap", int'(wrap), 0);
    wait_change("up2", 16'hFFFF);
    chk("up_wrap_val", int'(count), 0);
    chk("up_wrap_pulse", int'(wrap), 1);
    step();
    chk("up_wrap_end", int'(wrap), 0);

    dir = 0;
    do_load(16'h0001);
    wait_change("dn1", 16'h0001);
    chk("dn_0000", int'(count), 0);
    chk("dn_0000_wrap", int'(wrap), 0);
    wait_change("dn2", 16'h0000);
    chk("dn_ffff", int'(count), 'hFFFF);
    chk("dn_wrap_pulse", int'(wrap), 1);
    step();
    chk("dn_wrap_end", int'(wrap), 0);
    dir = 1; step(); dir = 0;
    chk("dir_glitch_hold", int'(count), 'hFFFF);
    wait_change("dn3", 16'hFFFF);
    chk("dn_fffe", int'(count), 'hFFFE);

    en = 0;
    frozen = count;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("scan_onehot", int'(anode == 4'hE || anode == 4'hD || anode == 4'hB || anode == 4'h7), 1);
    end
    chk("frozen", int'(count), int'(frozen));

    en = 1; dir = 1;
    for (int k = 0; k < 8 && m_pre != PS - 1; k++) step();
    chk("tick_align", m_pre, PS - 1);
    do_load(16'h1234);
    chk("load_beats_tick", int'(count), 'h1234);
    repeat (3) step();
    chk("load_restart_hold", int'(count), 'h1234);
    step();
    chk("load_restart_tick", int'(count), 'h1235);

    @(negedge clk);
    #3 rst_n = 0;
    model_reset();
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_anode", int'(anode), 'hF);
    chk("midrst_seg", int'(seg), 'h7F);
    repeat (2) step();
    rst_n = 1;
    step();
    chk("rel_anode", int'(anode), 'hE);
    chk("rel_seg", int'(seg), 'h40);

    en = 0;
    foreach (vecs[v]) begin
      do_load(vecs[v].value);
      for (int i = 0; i < 2 * ND * SD; i++) begin
        step();
        d = (anode == 4'hE) ? 0 : (anode == 4'hD) ? 1 : (anode == 4'hB) ? 2 : 3;
        chk($sformatf("glyph_%h_d%0d", vecs[v].value, d), int'(seg), int'(vecs[v].segs[d]));
      end
    end

    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      dir = ($urandom_range(0, 31) == 0) ? ~dir : dir;
      ld = ($urandom_range(0, 23) == 0);
      case ($urandom_range(0, 3))
        0: lv = 16'hFFFF;
        1: lv = 16'h0000;
        default: lv = 16'($urandom_range(0, 65535));
      endcase
      step();
    end
    ld = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/seg7_scan_counter.md
Name: seg7_scan_counter

Overview:
- Parametrised successor to the lab's fixed 9-bit system counter.
- Holds an N-digit hex up/down counter, advanced by a prescaled tick, with synchronous load and a wrap flag.
- Time-multiplexes the counter onto a common-anode multi-digit 7-segment display.
- Sits between the board clock/reset and the display pins; `count` is also exported for the bench and for other logic.

Parameters:
- NUM_DIGITS, 4, number of display digits; counter width is CW = 4*NUM_DIGITS.
- PRESCALE, 50000, system_clock cycles per count tick; must be >= 1.
- SCAN_DIV, 1000, system_clock cycles per digit during scanning; must be >= 1.

Ports:
- system_clock  in  1  single design clock; all state changes on its rising edge.
- system_reset  in  1  asynchronous, active-low reset; asserted when 0.
- count_en  in  1  1 = prescaler runs and ticks advance the counter.
- count_dir  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_value  in  CW  value loaded into the counter.
- count  out  CW  current counter value.
- wrap  out  1  one-cycle pulse when the counter wraps.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- anode  out  NUM_DIGITS  digit enables, active-low, one-hot-cold.

Behaviour:
- Reset (system_reset=0, asynchronous): count=0, prescaler=0, scan divider=0, digit index=0, wrap=0, seg=7'h7F, anode=all ones (display dark). The reset state holds for as long as reset is low.
- Prescaler:
  - Counts 0..PRESCALE-1 only while count_en=1; holds its value while count_en=0.
  - tick=1 in the cycle where prescaler==PRESCALE-1 and count_en=1; the prescaler returns to 0 on the next edge.
  - With PRESCALE=1, tick=count_en every cycle.
- Counter update, evaluated at each edge, in priority order:
  1. load=1: count<=load_value, prescaler<=0, wrap<=0. Load beats a simultaneous tick.
  2. tick=1, count_dir=1: count<=count+1 mod 2^CW; wrap<=1 if count was all ones.
  3. tick=1, count_dir=0: count<=count-1 mod 2^CW; wrap<=1 if count was 0.
  4. Otherwise: count holds, wrap<=0.
- wrap is registered, so it is high for exactly the cycle after the wrapping edge.
- count_dir is sampled only on tick cycles; changing it mid-period has no other effect.
- Scanner:
  - Free-running and independent of count_en.
  - The scan divider counts 0..SCAN_DIV-1.
  - At terminal count, the digit index advances 0,1,..,NUM_DIGITS-1,0 (wrap-around).
- Display outputs:
  - seg and anode are registered and updated every cycle from the current digit index and count.
  - Latency is 1 cycle from an index or count change to the pins.
  - anode = ~(1 << idx).
  - seg = active-low hex glyph of count[4*idx+3 : 4*idx], covering digits 0-F.
  - The first non-reset outputs appear on the first edge after reset deassertion: digit 0 enabled.
- Reset mid-operation clears everything asynchronously; no tick or wrap is generated on the release edge.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined: a digit idx>0 whose nibble and all higher nibbles are 0 drives seg=7'h7F while its anode is still asserted. Digit 0 is never blanked. Example: count=16'h0005 shows "   5".
- When undefined: every digit always shows its glyph. Example: count=16'h0005 shows "0005".
- Count and wrap behaviour are identical in both builds.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'h7F;
  - the 16-entry active-low hex glyph constant table (0 = 7'h40, 1 = 7'h79, ..., F = 7'h0E);
  - the hex-to-glyph function.
- One sub-module, seg7_scan_mux, contains the scan divider, digit index, and registered seg/anode (including blanking).
- The top level contains the prescaler, counter, load and wrap logic.

Test Plan (NUM_DIGITS=4, PRESCALE=4, SCAN_DIV=2, 20 ns clock):
- Reset low for 100 ns, then high with count_en=1, count_dir=1 -> count=0 during reset; count=1 after 4 cycles; count=16'h0019 after 100 cycles; anode=4'hF, seg=7'h7F during reset.
- load=1 with load_value=16'hFFFE for 1 cycle, then count up -> count=16'hFFFF, then 16'h0000 with wrap high for exactly 1 cycle.
- load_value=16'h0001, count_dir=0 -> count goes 0000, then FFFF with wrap pulse; pulse count_dir=1 between ticks -> no extra count change.
- count_en=0 for 40 cycles -> count frozen, prescaler held; scanner keeps cycling anode E,D,B,7 every 2 cycles with matching glyphs.
- load and tick in the same cycle, load_value=16'h1234 -> count=16'h1234; next tick occurs 4 cycles later.
- count=16'h0005, checked in both builds -> digit 0 seg=7'h12 in both; digits 1-3 seg=7'h7F with LEADING_ZERO_BLANK_EN defined, 7'h40 without it.
